mem_responder: RTL and testbench

- Unified instruction/data memory that serves as the responding end of the multi-cycle core's memory interface.
- The core drives the address, write data, write strobe and a request, then waits for a ready pulse.
- The block adds a configurable wait-state count, byte-lane writes and error signalling for misaligned or out-of-range accesses.
- Its ReadData feeds the core's instruction register and data register paths.

---
 rtl/mem_responder.sv | 125 ++++++++++++
 tb/tb_mem_responder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: unified instruction/data memory that responds to the
// multi-cycle core's request/ready memory interface. It inserts LATENCY
// wait states, supports byte-lane writes, and flags misaligned or
// out-of-range accesses with MemErr.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      synchronous active-high reset
//   MemReq     access request, sampled only in IDLE
//   MemWrite   1 = write, 0 = read (sampled with MemReq)
//   Adr        byte address (sampled with MemReq)
//   WriteData  store data (sampled with MemReq)
//   ByteEn     write lane enables, bit i -> WriteData[8i+7:8i]
//   ReadData   registered read data, held until the next read response
//   MemReady   one-cycle response pulse
//   MemErr     fault flag, only ever high together with MemReady
//   Busy       high whenever the FSM is not IDLE
module mem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  input  logic [3:0]  ByteEn,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        MemErr,
  output logic        Busy
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, next_state;
  logic [3:0]  cnt;
  logic [31:0] req_adr;
  logic [31:0] req_wdata;
  logic        req_write;
  logic [3:0]  req_be;
  logic [31:0] rdata;
  logic [31:0] mem [DEPTH];

  function automatic logic is_fault(input logic [31:0] a);
    logic [31:0] off;
    off = a - ADDR_BASE;
    return (a[1:0] != 2'b00) || (a < ADDR_BASE) || ({1'b0, off} >= SPAN);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - ADDR_BASE;
    return off[AW+1:2];
  endfunction

  // With LATENCY=0 the read happens on the same edge that accepts the
  // request, so the live inputs are used in IDLE instead of the registers.
  logic [31:0] rd_adr;
  logic        rd_write;
  logic        enter_resp;

  always_comb begin
    rd_adr     = (state == IDLE) ? Adr : req_adr;
    rd_write   = (state == IDLE) ? MemWrite : req_write;
    enter_resp = (state != RESP) && (next_state == RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (MemReq) next_state = (LATENCY == 0) ? RESP : WAIT;
      WAIT:    if (cnt == '0) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      req_adr   <= '0;
      req_wdata <= '0;
      req_write <= 1'b0;
      req_be    <= '0;
      rdata     <= '0;
    end else begin
      if (state == IDLE && MemReq) begin
        req_adr   <= Adr;
        req_wdata <= WriteData;
        req_write <= MemWrite;
        req_be    <= ByteEn;
        cnt       <= (LATENCY > 0) ? 4'(LATENCY - 1) : '0;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp && !rd_write)
        rdata <= is_fault(rd_adr) ? '0 : mem[word_idx(rd_adr)];
    end
  end

  // Writes commit on the edge ending RESP; reset in that cycle aborts them.
  always_ff @(posedge clk) begin
    if (!reset && state == RESP && req_write && !is_fault(req_adr)) begin
      for (int unsigned i = 0; i < 4; i++)
        if (req_be[i]) mem[word_idx(req_adr)][8*i +: 8] <= req_wdata[8*i +: 8];
    end
  end

  assign ReadData = rdata;
  assign MemReady = (state == RESP);
  assign MemErr   = (state == RESP) && is_fault(req_adr);
  assign Busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder. Instance a uses
// LATENCY=2, instance b uses LATENCY=0 for back-to-back timing.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        req_a = 1'b0, wr_a = 1'b0;
  logic [31:0] adr_a = '0, wd_a = '0;
  logic [3:0]  be_a = '0;
  logic [31:0] rd_a;
  logic        rdy_a, err_a, busy_a;

  logic        req_b = 1'b0, wr_b = 1'b0;
  logic [31:0] adr_b = '0, wd_b = '0;
  logic [3:0]  be_b = '0;
  logic [31:0] rd_b;
  logic        rdy_b, err_b, busy_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(1024), .LATENCY(2), .ADDR_BASE(32'h0)) dut_a (
    .clk(clk), .reset(reset), .MemReq(req_a), .MemWrite(wr_a), .Adr(adr_a),
    .WriteData(wd_a), .ByteEn(be_a), .ReadData(rd_a), .MemReady(rdy_a),
    .MemErr(err_a), .Busy(busy_a)
  );

  mem_responder #(.DEPTH(1024), .LATENCY(0), .ADDR_BASE(32'h0)) dut_b (
    .clk(clk), .reset(reset), .MemReq(req_b), .MemWrite(wr_b), .Adr(adr_b),
    .WriteData(wd_b), .ByteEn(be_b), .ReadData(rd_b), .MemReady(rdy_b),
    .MemErr(err_b), .Busy(busy_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One access on dut_a: request during one cycle, wait for the pulse,
  // check latency, busy, and the return to IDLE in the following cycle.
  task automatic access(input string tag, input logic w, input logic [31:0] adr,
                        input logic [31:0] wd, input logic [3:0] be,
                        output logic [31:0] rdata, output logic err);
    int k;
    int busy_bad;
    req_a = 1'b1; wr_a = w; adr_a = adr; wd_a = wd; be_a = be;
    @(negedge clk);
    req_a = 1'b0;
    k = 1;
    busy_bad = 0;
    while (k <= 20) begin
      if (busy_a !== 1'b1) busy_bad++;
      if (rdy_a === 1'b1) break;
      if (err_a !== 1'b0) busy_bad++;
      k++;
      @(negedge clk);
    end
    check_eq({tag, "_lat"}, k, 3);
    check_eq({tag, "_busy"}, busy_bad, 0);
    rdata = rd_a;
    err   = err_a;
    @(negedge clk);
    check_eq({tag, "_idle"}, {rdy_a, err_a, busy_a}, 3'b000);
  endtask

  logic [31:0] rd;
  logic        er;
  logic [11:0] pat;

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_rdata", rd_a, 32'h0);
    check_eq("rst_flags", {rdy_a, err_a, busy_a}, 3'b000);
    reset = 1'b0;
    @(negedge clk);

    // 1: full write then read back
    access("w10", 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, rd, er);
    check_eq("w10_err", er, 1'b0);
    access("r10", 1'b0, 32'h10, 32'h0, 4'b0000, rd, er);
    check_eq("r10_data", rd, 32'hDEADBEEF);
    check_eq("r10_err", er, 1'b0);

    // 2: byte lanes 0 and 2, then empty-lane write
    access("wbe", 1'b1, 32'h10, 32'h11223344, 4'b0101, rd, er);
    access("rbe", 1'b0, 32'h10, 32'h0, 4'b0000, rd, er);
    check_eq("rbe_data", rd, 32'hDE22BE44);
    access("wbe0", 1'b1, 32'h10, 32'h99999999, 4'b0000, rd, er);
    check_eq("wbe0_err", er, 1'b0);
    access("rbe0", 1'b0, 32'h10, 32'h0, 4'b0000, rd, er);
    check_eq("rbe0_data", rd, 32'hDE22BE44);

    // 3: misaligned accesses
    access("rmis", 1'b0, 32'h12, 32'h0, 4'b0000, rd, er);
    check_eq("rmis_err", er, 1'b1);
    check_eq("rmis_data", rd, 32'h0);
    access("wmis", 1'b1, 32'h12, 32'hFFFFFFFF, 4'b1111, rd, er);
    check_eq("wmis_err", er, 1'b1);
    check_eq("wmis_data", rd, 32'h0);
    access("rmis2", 1'b0, 32'h10, 32'h0, 4'b0000, rd, er);
    check_eq("rmis2_data", rd, 32'hDE22BE44);

    // 4: range boundary
    access("w0", 1'b1, 32'h0, 32'h01020304, 4'b1111, rd, er);
    access("woor", 1'b1, 32'h1000, 32'hAAAA5555, 4'b1111, rd, er);
    check_eq("woor_err", er, 1'b1);
    access("r0", 1'b0, 32'h0, 32'h0, 4'b0000, rd, er);
    check_eq("r0_data", rd, 32'h01020304);
    access("wtop", 1'b1, 32'hFFC, 32'h5A5A5A5A, 4'b1111, rd, er);
    check_eq("wtop_err", er, 1'b0);
    access("rtop", 1'b0, 32'hFFC, 32'h0, 4'b0000, rd, er);
    check_eq("rtop_err", er, 1'b0);
    check_eq("rtop_data", rd, 32'h5A5A5A5A);

    // 5: MemReq held high
    req_a = 1'b1; wr_a = 1'b0; adr_a = 32'h10;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      pat[i] = rdy_a;
    end
    req_a = 1'b0;
    check_eq("hold_lat2", pat, 12'h444);
    check_eq("hold_lat2_data", rd_a, 32'hDE22BE44);
    req_b = 1'b1; wr_b = 1'b0; adr_b = 32'h10;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      pat[i] = rdy_b;
    end
    req_b = 1'b0;
    check_eq("hold_lat0", pat, 12'h555);
    @(negedge clk);

    // 6: reset in the RESP cycle aborts the write
    access("w20z", 1'b1, 32'h20, 32'h00000000, 4'b1111, rd, er);
    req_a = 1'b1; wr_a = 1'b1; adr_a = 32'h20; wd_a = 32'hCAFEF00D; be_a = 4'b1111;
    @(negedge clk);
    req_a = 1'b0;
    for (int k = 0; k < 20 && rdy_a !== 1'b1; k++) @(negedge clk);
    check_eq("abort_inresp", rdy_a, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("abort_flags", {rdy_a, busy_a}, 2'b00);
    check_eq("abort_rdata", rd_a, 32'h0);
    access("r20", 1'b0, 32'h20, 32'h0, 4'b0000, rd, er);
    check_eq("r20_data", rd, 32'h00000000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
